// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave memory: word-organised, byte-addressable, OKAY or two-cycle ERROR responses.
// Define AHB_SLV_WAIT_EN to stretch every legal data phase by WAIT_CYCLES wait states.
module ahb_slave_mem #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HWRITE,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DATA = 3'd1,
        S_ERR1 = 3'd2,
        S_ERR2 = 3'd3
`ifdef AHB_SLV_WAIT_EN
        , S_WAIT = 3'd4
`endif
    } state_t;

    state_t            state_q, state_d, accept_state;
    logic [IDX_W+1:0]  addr_q, addr_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;
    logic              accept, addr_err, load_rd, commit;
    logic [IDX_W-1:0]  rd_idx, wr_idx;
    logic [3:0]        be;
    logic [DATA_W-1:0] rd_word;
    logic              unused_bits;

`ifdef AHB_SLV_WAIT_EN
    localparam bit USE_WAIT = (WAIT_CYCLES > 0);
    localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);
    logic [3:0] cnt_q, cnt_d;
`else
    localparam bit USE_WAIT = 1'b0;
`endif

    assign unused_bits = ^{HBURST, HTRANS[0], 32'(WAIT_CYCLES)};

    assign accept   = HSEL & HREADY & HTRANS[1] & HREADYOUT;
    assign addr_err = ((HADDR >> 2) >= DEPTH_A) || (HSIZE > 3'b010)
                    || (HSIZE == 3'b001 && HADDR[0])
                    || (HSIZE == 3'b010 && HADDR[1:0] != 2'b00);

`ifdef AHB_SLV_WAIT_EN
    assign accept_state = addr_err ? S_ERR1 : (USE_WAIT ? S_WAIT : S_DATA);
`else
    assign accept_state = addr_err ? S_ERR1 : S_DATA;
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            hrdata_q <= '0;
`ifdef AHB_SLV_WAIT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
            hrdata_q <= hrdata_d;
`ifdef AHB_SLV_WAIT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
`ifdef AHB_SLV_WAIT_EN
        cnt_d   = cnt_q;
`endif
        if (accept) begin
            addr_d  = HADDR[IDX_W+1:0];
            write_d = HWRITE;
            size_d  = HSIZE[1:0];
        end
        case (state_q)
`ifdef AHB_SLV_WAIT_EN
            S_WAIT: begin
                if (cnt_q == LAST_WAIT) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`endif
            S_ERR1:  state_d = S_ERR2;
            default: state_d = accept ? accept_state : S_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state_q)
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2: HRESP = 1'b1;
`ifdef AHB_SLV_WAIT_EN
            S_WAIT: HREADYOUT = 1'b0;
`endif
            default: ;
        endcase
    end

    // Read data is captured on the edge that enters the DATA state for a read.
    always_comb begin
        load_rd = accept && !addr_err && !HWRITE && !USE_WAIT;
        rd_idx  = HADDR[IDX_W+1:2];
`ifdef AHB_SLV_WAIT_EN
        if (state_q == S_WAIT) begin
            load_rd = (cnt_q == LAST_WAIT) && !write_q;
            rd_idx  = addr_q[IDX_W+1:2];
        end
`endif
    end

    assign commit = (state_q == S_DATA) && write_q;
    assign wr_idx = addr_q[IDX_W+1:2];

    always_comb begin
        case (size_q)
            2'b00:   be = 4'b0001 << addr_q[1:0];
            2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // One byte-wide array per lane; a write committing on the same edge is forwarded to the read.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [MEM_DEPTH];

        always_ff @(posedge HCLK) begin
            if (commit && be[gi]) begin
                mem[wr_idx] <= HWDATA[gi*8 +: 8];
            end
        end

        assign rd_word[gi*8 +: 8] = (commit && be[gi] && wr_idx == rd_idx)
                                  ? HWDATA[gi*8 +: 8] : mem[rd_idx];
    end

    assign hrdata_d = load_rd ? rd_word : hrdata_q;
    assign HRDATA   = hrdata_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Randomised and directed bench for ahb_slave_mem against a byte-array transfer-level model.
`timescale 1ns/1ps
module tb_ahb_slave_mem;
    localparam int W =
`ifdef AHB_SLV_WAIT_EN
        2;
`else
        0;
`endif
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    logic        HCLK, HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;

    ahb_slave_mem #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(1024), .WAIT_CYCLES(2)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        bit sel; logic [1:0] trans; logic [31:0] addr; bit wr;
        logic [2:0] size; logic [31:0] wdata; logic [2:0] burst;
    } xfer_t;

    // One expected bus cycle of a data phase.
    typedef struct {
        bit rdy; bit resp; bit fin_rd; bit fin_wr; bit fin_err;
        logic [31:0] addr; logic [2:0] size; logic [31:0] wdata;
    } ph_t;

    xfer_t       stim_q[$];
    ph_t         sched[$];
    logic [31:0] rd_log[$];
    logic [7:0]  mm [4096];
    logic [31:0] exp_hrdata, dp_wdata, old_a, old_b;
    int          checks, errors, lowcnt, respcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic xfer_t mk(input bit sel, input logic [1:0] tr, input logic [31:0] a,
                                 input bit wr, input logic [2:0] sz, input logic [31:0] d,
                                 input logic [2:0] bu);
        xfer_t t;
        t.sel = sel; t.trans = tr; t.addr = a; t.wr = wr; t.size = sz; t.wdata = d; t.burst = bu;
        return t;
    endfunction

    function automatic ph_t blank_ph(input bit rdy, input bit resp);
        ph_t p;
        p.rdy = rdy; p.resp = resp; p.fin_rd = 0; p.fin_wr = 0; p.fin_err = 0;
        p.addr = '0; p.size = '0; p.wdata = '0;
        return p;
    endfunction

    function automatic logic [31:0] mword(input logic [31:0] a);
        int b;
        b = int'(a) & 32'hFFC;
        return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
    endfunction

    function automatic bit is_err(input xfer_t t);
        return (t.addr >= 32'd4096) || (t.size > 3'd2) || (t.size == 3'd1 && t.addr[0])
            || (t.size == 3'd2 && t.addr[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] rd_at(input int i);
        return (rd_log.size() > i) ? rd_log[i] : 32'hxxxxxxxx;
    endfunction

    task automatic commit(input ph_t e);
        int n, a;
        n = 1 << e.size;
        for (int k = 0; k < n; k++) begin
            a = int'(e.addr) + k;
            mm[a] = e.wdata[8*(a%4) +: 8];
        end
    endtask

    // One bus cycle: drive address phase if the model says the bus is ready, check at negedge.
    task automatic step(input bit rst_mid);
        ph_t e, p;
        xfer_t t;
        e = blank_ph(1'b1, 1'b0);
        if (sched.size() > 0) e = sched[0];
        if (e.rdy) begin
            if (stim_q.size() > 0) t = stim_q.pop_front();
            else t = mk(1'b1, T_IDLE, 32'h0, 1'b0, 3'd2, 32'h0, 3'd0);
            HSEL = t.sel; HTRANS = t.trans; HADDR = t.addr; HWRITE = t.wr;
            HSIZE = t.size; HBURST = t.burst;
        end
        HREADY = e.rdy;
        HWDATA = dp_wdata;
        @(negedge HCLK);
        chk("hreadyout", HREADYOUT, e.rdy);
        chk("hresp", HRESP, e.resp);
        if (e.fin_rd) begin
            exp_hrdata = mword(e.addr);
            rd_log.push_back(HRDATA);
        end
        chk("hrdata", HRDATA, exp_hrdata);
        if (HREADYOUT === 1'b0) lowcnt++;
        if (HRESP === 1'b1) respcnt++;
        if (e.fin_rd || e.fin_wr || e.fin_err)
            $display("xfer %s addr=%h data=%h", e.fin_err ? "err" : (e.fin_wr ? "wr" : "rd"),
                     e.addr, e.fin_rd ? HRDATA : e.wdata);
        if (rst_mid) begin
            #2 HRESET = 1'b1;
            HTRANS = T_IDLE;
            #1;
            chk("rst_hreadyout", HREADYOUT, 1'b1);
            chk("rst_hresp", HRESP, 1'b0);
            chk("rst_hrdata", HRDATA, 32'h0);
            sched.delete();
            exp_hrdata = '0;
            @(posedge HCLK);
            #1 HRESET = 1'b0;
            return;
        end
        if (e.fin_wr) commit(e);
        if (sched.size() > 0) void'(sched.pop_front());
        if (e.rdy && t.sel && t.trans[1]) begin
            if (is_err(t)) begin
                sched.push_back(blank_ph(1'b0, 1'b1));
                p = blank_ph(1'b1, 1'b1);
                p.fin_err = 1'b1; p.addr = t.addr;
                sched.push_back(p);
            end else begin
                for (int k = 0; k < W; k++) sched.push_back(blank_ph(1'b0, 1'b0));
                p = blank_ph(1'b1, 1'b0);
                p.fin_rd = !t.wr; p.fin_wr = t.wr; p.addr = t.addr; p.size = t.size; p.wdata = t.wdata;
                sched.push_back(p);
            end
            if (t.wr) dp_wdata = t.wdata;
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic run_all();
        int n;
        n = 0;
        while ((stim_q.size() > 0 || sched.size() > 0) && n < 5000) begin
            step(1'b0);
            n++;
        end
    endtask

    task automatic start_group();
        rd_log.delete();
        lowcnt = 0;
        respcnt = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; lowcnt = 0; respcnt = 0;
        exp_hrdata = '0; dp_wdata = '0;
        for (int i = 0; i < 4096; i++) mm[i] = 8'h00;
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HTRANS = T_IDLE;
        HSIZE = 3'd2; HBURST = 3'd0; HWDATA = '0; HREADY = 1'b1;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("reset_hreadyout", HREADYOUT, 1'b1);
        chk("reset_hresp", HRESP, 1'b0);
        chk("reset_hrdata", HRDATA, 32'h0);
        @(posedge HCLK);
        #1 HRESET = 1'b0;

        // Preload words 0..63 so every later read address has known content.
        for (int i = 0; i < 64; i++)
            stim_q.push_back(mk(1, T_NSEQ, 32'(4*i), 1, 3'd2, $urandom() | 32'h1, 3'd0));
        run_all();

        start_group();
        stim_q.push_back(mk(1, T_NSEQ, 32'h10, 1, 3'd2, 32'hDEADBEEF, 3'd0));
        stim_q.push_back(mk(1, T_NSEQ, 32'h10, 0, 3'd2, 32'h0, 3'd0));
        run_all();
        chk("single_word_rd", rd_at(0), 32'hDEADBEEF);
        chk("single_word_waits", lowcnt, 2*W);

        start_group();
        stim_q.push_back(mk(1, T_NSEQ, 32'h0, 1, 3'd2, 32'h11223344, 3'd0));
        stim_q.push_back(mk(1, T_NSEQ, 32'h1, 1, 3'd0, 32'h0000AA00, 3'd0));
        stim_q.push_back(mk(1, T_NSEQ, 32'h2, 1, 3'd1, 32'hBEEF0000, 3'd0));
        stim_q.push_back(mk(1, T_NSEQ, 32'h0, 0, 3'd2, 32'h0, 3'd0));
        run_all();
        chk("lanes_rd", rd_at(0), 32'hBEEFAA44);

        for (int i = 0; i < 4; i++)
            stim_q.push_back(mk(1, (i == 0) ? T_NSEQ : T_SEQ, 32'h20 + 32'(4*i), 1, 3'd2, 32'(i+1), 3'd3));
        run_all();
        start_group();
        stim_q.push_back(mk(1, T_NSEQ, 32'h28, 0, 3'd2, 32'h0, 3'd2));
        stim_q.push_back(mk(1, T_SEQ,  32'h2C, 0, 3'd2, 32'h0, 3'd2));
        stim_q.push_back(mk(1, T_SEQ,  32'h20, 0, 3'd2, 32'h0, 3'd2));
        stim_q.push_back(mk(1, T_SEQ,  32'h24, 0, 3'd2, 32'h0, 3'd2));
        run_all();
        chk("wrap_beat0", rd_at(0), 32'd3);
        chk("wrap_beat1", rd_at(1), 32'd4);
        chk("wrap_beat2", rd_at(2), 32'd1);
        chk("wrap_beat3", rd_at(3), 32'd2);
        chk("wrap_waits", lowcnt, 4*W);

        start_group();
        stim_q.push_back(mk(1, T_NSEQ, 32'h1000, 0, 3'd2, 32'h0, 3'd0));
        stim_q.push_back(mk(1, T_NSEQ, 32'h3, 1, 3'd1, 32'h12345678, 3'd0));
        stim_q.push_back(mk(1, T_NSEQ, 32'h0, 0, 3'd2, 32'h0, 3'd0));
        run_all();
        chk("err_resp_cycles", respcnt, 4);
        chk("err_low_cycles", lowcnt, 2 + W);
        chk("err_mem_unchanged", rd_at(0), 32'hBEEFAA44);

        start_group();
        old_a = mword(32'h38);
        stim_q.push_back(mk(1, T_NSEQ, 32'h30, 1, 3'd2, 32'h0000000A, 3'd1));
        stim_q.push_back(mk(1, T_BUSY, 32'h34, 1, 3'd2, 32'h0, 3'd1));
        stim_q.push_back(mk(1, T_SEQ,  32'h34, 1, 3'd2, 32'h0000000B, 3'd1));
        stim_q.push_back(mk(1, T_IDLE, 32'h38, 1, 3'd2, 32'h0, 3'd0));
        stim_q.push_back(mk(0, T_NSEQ, 32'h38, 1, 3'd2, 32'h55555555, 3'd0));
        stim_q.push_back(mk(1, T_NSEQ, 32'h30, 0, 3'd2, 32'h0, 3'd1));
        stim_q.push_back(mk(1, T_SEQ,  32'h34, 0, 3'd2, 32'h0, 3'd1));
        stim_q.push_back(mk(1, T_SEQ,  32'h38, 0, 3'd2, 32'h0, 3'd1));
        run_all();
        chk("busy_rd0", rd_at(0), 32'h0000000A);
        chk("busy_rd1", rd_at(1), 32'h0000000B);
        chk("hsel0_no_write", rd_at(2), old_a);

        // Reset pulsed in the first data-phase cycle of a write: the write must be lost.
        old_b = mword(32'h40);
        stim_q.push_back(mk(1, T_NSEQ, 32'h40, 0, 3'd2, 32'h0, 3'd0));
        run_all();
        stim_q.push_back(mk(1, T_NSEQ, 32'h40, 1, 3'd2, 32'hCAFEF00D, 3'd0));
        step(1'b0);
        step(1'b1);
        start_group();
        stim_q.push_back(mk(1, T_NSEQ, 32'h40, 0, 3'd2, 32'h0, 3'd0));
        run_all();
        chk("rst_write_dropped", rd_at(0), old_b);

        for (int i = 0; i < 400; i++) begin
            xfer_t t;
            int r;
            r = $urandom_range(0, 99);
            t.sel = (r < 90);
            t.trans = (r < 75) ? ($urandom_range(0, 1) ? T_NSEQ : T_SEQ) : ((r < 85) ? T_IDLE : T_BUSY);
            t.size = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            t.addr = 32'($urandom_range(0, 255));
            if (t.size <= 3'd2 && $urandom_range(0, 9) != 0)
                t.addr = t.addr & ~(32'(1 << t.size) - 32'd1);
            if ($urandom_range(0, 29) == 0)
                t.addr = ($urandom_range(0, 1) != 0) ? 32'h1000 + 32'($urandom_range(0, 255) * 4) : 32'hFFFFFFFC;
            t.wr = ($urandom_range(0, 1) != 0);
            t.wdata = $urandom();
            t.burst = 3'($urandom_range(0, 7));
            stim_q.push_back(t);
        end
        run_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
